// File: rtl/down_counter.sv
// down_counter: loadable countdown timer with IDLE/RUN/EXPIRE sequencing.
//
// Optional feature: define DOWN_COUNTER_AUTO_RELOAD_EN to reload the last
// start value on expiry and keep counting (periodic mode).
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   reset    in   synchronous active-high reset
//   start    in   in IDLE: load load_val and begin a countdown
//   load_val in   [WIDTH] countdown start value
//   enable   in   in RUN: decrement this cycle (low = hold)
//   abort    in   in RUN: terminate countdown (count -> 0, no done)
//   count    out  [WIDTH] current registered count
//   busy     out  high while in RUN
//   done     out  one-cycle pulse while in EXPIRE
//   zero     out  combinational: count == 0
module down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Next-state, next-count and next-output decode
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    reload_d = load_val;
`endif
                    // A zero load expires immediately without entering RUN
                    state_d = (load_val != '0) ? RUN : EXPIRE;
                end
            end

            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (enable) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (count_q == WIDTH'(1)) begin
                        count_d = '0;
                        state_d = EXPIRE;
                    end
                end
            end

            EXPIRE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                if (abort || (reload_q == '0)) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = reload_q;
                    state_d = RUN;
                end
`else
                count_d = '0;
                state_d = IDLE;
`endif
            end

            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs track the state being entered so they line up with it
        busy_d = (state_d == RUN);
        done_d = (state_d == EXPIRE);
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed vectors with literal expectations plus a
// per-cycle comparison against a flag-based behavioural model.
// Honours DOWN_COUNTER_AUTO_RELOAD_EN to match the design build.
`timescale 1ns/1ps
module tb_down_counter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] load_val;
    logic         enable;
    logic         abort;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_val (load_val),
        .enable   (enable),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Behavioural model: the phase is carried by two flags (counting /
    // expiring); neither set means idle.
    int  m_cnt;
    int  m_reload;
    bit  m_counting;
    bit  m_expiring;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_reload = 0; m_counting = 0; m_expiring = 0;
            m_valid = 1'b1;
        end else if (m_expiring) begin
            m_expiring = 0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            if (!abort && m_reload != 0) begin
                m_cnt = m_reload;
                m_counting = 1;
            end else begin
                m_cnt = 0;
            end
`else
            m_cnt = 0;
`endif
        end else if (m_counting) begin
            if (abort) begin
                m_cnt = 0;
                m_counting = 0;
            end else if (enable && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_counting = 0;
                    m_expiring = 1;
                end
            end
        end else if (start) begin
            m_cnt = int'(load_val);
            m_reload = int'(load_val);
            if (m_cnt == 0) m_expiring = 1;
            else            m_counting = 1;
        end
    end

    // Compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (int'(count) != m_cnt || busy != m_counting || done != m_expiring
                || zero != (m_cnt == 0)) begin
                failures++;
                $display("FAIL model t=%0t count=%0d/%0d busy=%0b/%0b done=%0b/%0b zero=%0b (got/required)",
                         $time, count, m_cnt, busy, m_counting, done, m_expiring, zero);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int c, input bit b, input bit d);
        checks++;
        if (int'(count) != c || busy != b || done != d || zero != (c == 0)) begin
            failures++;
            $display("FAIL %s count=%0d busy=%0b done=%0b zero=%0b required count=%0d busy=%0b done=%0b",
                     name, count, busy, done, zero, c, b, d);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_val = '0; enable = 1'b0; abort = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset", 0, 0, 0);

        // Load 3, enable held: 3,2,1,0 then done
        load_val = 8'd3; start = 1'b1; enable = 1'b1;
        tick(); chk("ld3_c3", 3, 1, 0);
        start = 1'b0;
        tick(); chk("ld3_c2", 2, 1, 0);
        tick(); chk("ld3_c1", 1, 1, 0);
        tick(); chk("ld3_done", 0, 0, 1);
        tick();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        chk("ld3_reload", 3, 1, 0);
        abort = 1'b1;
        tick(); chk("ld3_abort", 0, 0, 0);
        abort = 1'b0;
`else
        chk("ld3_idle", 0, 0, 0);
`endif

        // Load 5, enable toggling: decrement only on enabled edges
        load_val = 8'd5; start = 1'b1; enable = 1'b0;
        tick(); chk("ld5_c5", 5, 1, 0);
        start = 1'b0;
        enable = 1'b1; tick(); chk("ld5_en1", 4, 1, 0);
        enable = 1'b0; tick(); chk("ld5_en0", 4, 1, 0);
        enable = 1'b1; tick(); chk("ld5_en1b", 3, 1, 0);
        enable = 1'b0; tick(); chk("ld5_en0b", 3, 1, 0);
        abort = 1'b1; tick(); chk("ld5_abort", 0, 0, 0);
        abort = 1'b0;

        // Load 0: straight to expiry, never busy
        load_val = 8'd0; start = 1'b1;
        tick(); chk("ld0_done", 0, 0, 1);
        start = 1'b0;
        tick(); chk("ld0_idle", 0, 0, 0);

        // Load 4; start in RUN ignored; abort beats enable
        load_val = 8'd4; start = 1'b1; enable = 1'b0;
        tick(); chk("ld4_c4", 4, 1, 0);
        load_val = 8'd9;
        tick(); chk("ld4_start_ign", 4, 1, 0);
        start = 1'b0; abort = 1'b1; enable = 1'b1;
        tick(); chk("ld4_abort", 0, 0, 0);
        abort = 1'b0; enable = 1'b0;
        tick(); chk("ld4_nodone", 0, 0, 0);

        // Idle ignores enable/abort
        abort = 1'b1; enable = 1'b1;
        tick(); chk("idle_ign", 0, 0, 0);
        abort = 1'b0; enable = 1'b0;

        // Reset mid-countdown at count 7
        load_val = 8'd7; start = 1'b1;
        tick(); chk("ld7_c7", 7, 1, 0);
        start = 1'b0; reset = 1'b1; enable = 1'b1;
        tick(); chk("ld7_reset", 0, 0, 0);
        reset = 1'b0;
        tick(); chk("ld7_after", 0, 0, 0);

        // Reset during expiry
        load_val = 8'd1; start = 1'b1; enable = 1'b1;
        tick(); chk("ld1_c1", 1, 1, 0);
        start = 1'b0;
        tick(); chk("ld1_done", 0, 0, 1);
        reset = 1'b1;
        tick(); chk("ld1_reset", 0, 0, 0);
        reset = 1'b0;

        // Abort during expiry: done still pulses, then idle in both builds
        load_val = 8'd1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); chk("exp_abort_done", 0, 0, 1);
        abort = 1'b1;
        tick(); chk("exp_abort_idle", 0, 0, 0);
        abort = 1'b0;

        // Load 2: periodic with reload, single shot without
        load_val = 8'd2; start = 1'b1; enable = 1'b1;
        tick(); chk("ld2_c2", 2, 1, 0);
        start = 1'b0;
        tick(); chk("ld2_c1", 1, 1, 0);
        tick(); chk("ld2_done", 0, 0, 1);
        tick();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        chk("ld2_p2_c2", 2, 1, 0);
        tick(); chk("ld2_p2_c1", 1, 1, 0);
        tick(); chk("ld2_p2_done", 0, 0, 1);
        tick(); chk("ld2_p3_c2", 2, 1, 0);
        abort = 1'b1;
        tick(); chk("ld2_abort", 0, 0, 0);
        abort = 1'b0;
`else
        chk("ld2_idle", 0, 0, 0);
        tick(); chk("ld2_stay", 0, 0, 0);
`endif

        // Pseudo-random tail, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 3) == 0);
            load_val = W'($urandom_range(0, 6));
            enable   = ($urandom_range(0, 3) != 0);
            abort    = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0; enable = 1'b0; abort = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and load-value width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: in IDLE, loads load_val and begins a countdown.
REQ-005 The block SHALL have port load_val, input, WIDTH bits: the countdown start value, sampled only when start is accepted.
REQ-006 The block SHALL have port enable, input, 1 bit: in RUN, decrement the count this cycle; low means hold.
REQ-007 The block SHALL have port abort, input, 1 bit: in RUN, terminate the countdown.
REQ-008 The block SHALL have port count, output, WIDTH bits: the current registered count value.
REQ-009 The block SHALL have port busy, output, 1 bit: high in the RUN state.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse, high in the EXPIRE state.
REQ-011 The block SHALL have port zero, output, 1 bit: high when count equals 0 (combinational from count).

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and EXPIRE, with busy=1 only in RUN and done=1 only in EXPIRE.
REQ-013 In IDLE with start=1, the next edge SHALL load count<=load_val and reload_reg<=load_val, and SHALL move to RUN if load_val!=0 or to EXPIRE if load_val==0.
REQ-014 In IDLE with start=0, the count SHALL hold and the state SHALL remain IDLE; enable and abort SHALL be ignored.
REQ-015 In RUN, precedence SHALL be abort > enable: abort=1 clears count to 0 and moves to IDLE with no done pulse.
REQ-016 In RUN with enable=1 and count>1, the count SHALL decrement by 1.
REQ-017 In RUN with enable=1 and count==1, the count SHALL become 0 and the state SHALL move to EXPIRE.
REQ-018 In RUN with enable=0, the count and state SHALL hold.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 The count SHALL never wrap below 0; no decrement SHALL occur from 0.
REQ-021 EXPIRE SHALL last exactly one cycle; its successor is defined in REQ-026/REQ-027.
REQ-022 Latency: with start accepted at edge N and enable held high, count SHALL reach 0 at edge N+load_val and done SHALL be high for the cycle following that edge.

Reset
REQ-023 When reset=1 at a rising edge of clk, the state SHALL become IDLE, count and reload_reg SHALL become 0, and busy and done SHALL be 0; zero SHALL then be 1.
REQ-024 reset SHALL take priority over start, abort and enable in every state, including mid-countdown and during EXPIRE.
REQ-025 There SHALL be no asynchronous reset path.

Configuration
REQ-026 With macro DOWN_COUNTER_AUTO_RELOAD_EN defined, EXPIRE SHALL load count<=reload_reg and move to RUN if reload_reg!=0, otherwise move to IDLE; abort=1 during EXPIRE SHALL move to IDLE with count 0, and done SHALL still pulse in that cycle.
REQ-027 With DOWN_COUNTER_AUTO_RELOAD_EN undefined, EXPIRE SHALL always move to IDLE with count 0, reload_reg MAY be omitted, and abort SHALL have no effect in EXPIRE.

Verification
REQ-028 Bench SHALL check: reset, then start with load_val=3 and enable=1 -> count 3,2,1,0 on successive edges, then done=1 for one cycle, then IDLE with busy=0.
REQ-029 Bench SHALL check: load_val=5 with enable toggling 1,0,1,0 -> count decrements only on enable=1 edges and busy=1 throughout RUN.
REQ-030 Bench SHALL check: start with load_val=0 -> EXPIRE on the next cycle, done=1 for one cycle, busy never high.
REQ-031 Bench SHALL check: abort and enable both high in RUN with count=4 -> IDLE, count=0, done never asserted; start during RUN has no effect.
REQ-032 Bench SHALL check: reset asserted in RUN with count=7 -> IDLE, count=0, busy=0 after that edge, and no done pulse.
REQ-033 Bench SHALL check, with DOWN_COUNTER_AUTO_RELOAD_EN: load_val=2 -> count 2,1,0,2,1,0... with a done pulse each period (period 3 cycles); without the macro, a single done pulse followed by IDLE.
